vga_line_buffer: RTL and testbench

Double-banked (ping-pong) line buffer between a pixel producer and the VGA output stage. It accepts one scanline of 12-bit RGB pixels per line over a valid/ready handshake. It replays the completed line in lock-step with the timing generator's active-pixel strobe. It also decouples producer bursts from the fixed raster rate and reports line underflow.

---
 rtl/vga_line_buffer.sv | 154 +++++++++++++++
 tb/tb_vga_line_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong scanline buffer between a pixel producer and the
// VGA output stage. Two banks alternate between filling from the producer and
// replaying to the raster on pix_en. The underflow flag is sticky.
// Optional feature macro: VGA_LINE_BUFFER_REPEAT_EN. When it is defined, an
// underflowing line repeats the previously displayed bank instead of going black.
//
// Handshake: a pixel transfers on a rising clk edge when in_valid && in_ready.
// in_ready is a function of registered bank state only, so it never depends
// on in_valid. The producer must hold in_data/in_last stable while in_valid is
// high and in_ready is low.
module vga_line_buffer #(
    parameter int LINE_WIDTH = 1280,
    parameter int PIXEL_BITS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIXEL_BITS-1:0] in_data,
    input  logic                  in_last,
    input  logic                  line_start,
    input  logic                  pix_en,
    output logic [3:0]            R,
    output logic [3:0]            G,
    output logic [3:0]            B,
    output logic                  underflow,
    output logic [3:0]            bank_state   // {bank1 state, bank0 state}
);

    localparam int AW = $clog2(LINE_WIDTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

    bank_state_t           st    [2];
    bank_state_t           st_nx [2];
    logic [PW-1:0]         len   [2];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  last_closed;
    logic [PIXEL_BITS-1:0] rgb;
    logic [PIXEL_BITS-1:0] mem [2][LINE_WIDTH];

    logic filling, wr_bank, reading, rd_bank;
    logic xfer, close, full0, full1, have_full, pick;

    assign in_ready   = filling;
    assign R          = rgb[11:8];
    assign G          = rgb[7:4];
    assign B          = rgb[3:0];
    assign bank_state = {st[1], st[0]};

    // Bank next-state: close, fill start, read swap. Each event acts on a
    // distinct current state, so no two events ever target the same bank.
    always_comb begin
        st_nx     = st;
        filling   = (st[0] == FILLING) || (st[1] == FILLING);
        wr_bank   = (st[1] == FILLING);
        reading   = (st[0] == READING) || (st[1] == READING);
        rd_bank   = (st[1] == READING);
        xfer      = in_valid && filling;
        close     = xfer && (in_last || (wr_ptr == PW'(LINE_WIDTH - 1)));
        full0     = (st[0] == FULL);
        full1     = (st[1] == FULL);
        have_full = full0 || full1;
        // With both banks full the older one (not the last closed) goes first.
        pick      = (full0 && full1) ? ~last_closed : full1;

        if (close) begin
            st_nx[wr_bank] = FULL;
        end

        // A bank freed this cycle is still READING here, so it can only
        // start filling one cycle later.
        if (!filling) begin
            if (st[0] == EMPTY) begin
                st_nx[0] = FILLING;
            end else if (st[1] == EMPTY) begin
                st_nx[1] = FILLING;
            end
        end

        // A bank closing this cycle is still FILLING, so it is not eligible.
        if (line_start) begin
            if (have_full) begin
                if (reading) begin
                    st_nx[rd_bank] = EMPTY;
                end
                st_nx[pick] = READING;
            end else begin
`ifdef VGA_LINE_BUFFER_REPEAT_EN
                // Keep the current READING bank so the previous line repeats.
                st_nx = st_nx;
`else
                if (reading) begin
                    st_nx[rd_bank] = EMPTY;
                end
`endif
            end
        end
    end

    // Bank states, pointers, lengths and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            st[0]       <= EMPTY;
            st[1]       <= EMPTY;
            len[0]      <= '0;
            len[1]      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_closed <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            st <= st_nx;
            if (xfer) begin
                if (close) begin
                    len[wr_bank] <= wr_ptr + 1'b1;
                    wr_ptr       <= '0;
                    last_closed  <= wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (line_start) begin
                rd_ptr <= '0;
                if (!have_full) begin
                    underflow <= 1'b1;
                end
            end else if (pix_en && (rd_ptr != PW'(LINE_WIDTH))) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Pixel storage write port.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_bank][wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Registered read: black unless pix_en hits a stored pixel of the READING bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
        end else if (pix_en && reading && (rd_ptr < len[rd_bank])) begin
            rgb <= mem[rd_bank][rd_ptr[AW-1:0]];
        end else begin
            rgb <= '0;
        end
    end

endmodule

// File: tb/tb_vga_line_buffer.sv
// tb_vga_line_buffer: directed bench for vga_line_buffer. A short cycle-by-cycle
// vector table is followed by hand-written multi-line sequences.
// Honours VGA_LINE_BUFFER_REPEAT_EN for the underflow-repeat expectation.
module tb_vga_line_buffer;

    localparam int LW = 1280;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_en = 1'b0;
    logic [3:0]  R, G, B;
    logic        underflow;
    logic [3:0]  bank_state;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q [$];

    typedef struct {
        logic        rst;
        logic        valid;
        logic [11:0] data;
        logic        last;
        logic        ls;
        logic        pe;
        logic        exp_ready;
        logic [11:0] exp_rgb;
        logic        exp_uf;
    } vec_t;

    vec_t vtab [15];

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    vga_line_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .line_start (line_start),
        .pix_en     (pix_en),
        .R          (R),
        .G          (G),
        .B          (B),
        .underflow  (underflow),
        .bank_state (bank_state)
    );

    function automatic vec_t mk(input logic r, input logic v, input logic [11:0] d,
                                input logic l, input logic ls, input logic pe,
                                input logic er, input logic [11:0] ergb, input logic euf);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.ls = ls; x.pe = pe;
        x.exp_ready = er; x.exp_rgb = ergb; x.exp_uf = euf;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; line_start = 1'b0; pix_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_pix(input logic [11:0] d, input logic last);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("push_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic push_line(input int n, input logic [11:0] xv, input logic last_on_end);
        for (int i = 0; i < n; i++) begin
            push_pix(12'(i) ^ xv, last_on_end && (i == n - 1));
        end
    endtask

    task automatic line_pulse();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    // n pix_en strobes; pixels below len carry index^xv, the rest are black.
    task automatic read_line(input int n, input int len, input logic [11:0] xv);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back((k < len) ? (12'(k) ^ xv) : 12'h000);
            pix_en = 1'b1;
            step();
            chk($sformatf("pixel%0d", k), 32'({R, G, B}), 32'(exp_q.pop_front()));
        end
        pix_en = 1'b0;
        step();
        chk("blank_after_line", 32'({R, G, B}), 32'h0);
    endtask

    initial begin
        logic [11:0] rep_pix;
`ifdef VGA_LINE_BUFFER_REPEAT_EN
        rep_pix = 12'h123;
`else
        rep_pix = 12'h000;
`endif
        //            rst  v   data     l  ls pe  rdy rgb      uf
        vtab[0]  = mk(1, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0);
        vtab[1]  = mk(0, 0, 12'h000, 0, 0, 0, 1, 12'h000, 0);
        vtab[2]  = mk(0, 1, 12'h123, 0, 0, 0, 1, 12'h000, 0);
        vtab[3]  = mk(0, 1, 12'h456, 0, 0, 0, 1, 12'h000, 0);
        vtab[4]  = mk(0, 1, 12'hABC, 1, 0, 0, 0, 12'h000, 0);
        vtab[5]  = mk(0, 0, 12'h000, 0, 0, 0, 1, 12'h000, 0);
        vtab[6]  = mk(0, 0, 12'h000, 0, 1, 0, 1, 12'h000, 0);
        vtab[7]  = mk(0, 0, 12'h000, 0, 0, 1, 1, 12'h123, 0);
        vtab[8]  = mk(0, 0, 12'h000, 0, 0, 1, 1, 12'h456, 0);
        vtab[9]  = mk(0, 0, 12'h000, 0, 0, 0, 1, 12'h000, 0);
        vtab[10] = mk(0, 0, 12'h000, 0, 0, 1, 1, 12'hABC, 0);
        vtab[11] = mk(0, 0, 12'h000, 0, 0, 1, 1, 12'h000, 0);
        vtab[12] = mk(0, 0, 12'h000, 0, 1, 0, 1, 12'h000, 1);
        vtab[13] = mk(0, 0, 12'h000, 0, 0, 1, 1, rep_pix, 1);
        vtab[14] = mk(1, 0, 12'h000, 0, 0, 1, 0, 12'h000, 0);

        // vector table: reset, short 3-pixel line, replay, blanking, underflow
        for (int i = 0; i < 15; i++) begin
            rst = vtab[i].rst; in_valid = vtab[i].valid; in_data = vtab[i].data;
            in_last = vtab[i].last; line_start = vtab[i].ls; pix_en = vtab[i].pe;
            step();
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vtab[i].exp_ready));
            chk($sformatf("vec%0d_rgb", i), 32'({R, G, B}), 32'(vtab[i].exp_rgb));
            chk($sformatf("vec%0d_uf", i), 32'(underflow), 32'(vtab[i].exp_uf));
        end
        in_valid = 1'b0; in_last = 1'b0; line_start = 1'b0; pix_en = 1'b0;

        // full line closed by count, replayed in full
        do_reset();
        push_line(LW, 12'h000, 1'b0);
        chk("s1_ready_bubble", 32'(in_ready), 32'd0);
        step();
        chk("s1_ready_bank_b", 32'(in_ready), 32'd1);
        line_pulse();
        read_line(LW, LW, 12'h000);
        chk("s1_underflow", 32'(underflow), 32'd0);

        // two full lines: write side stalls until a bank is freed
        do_reset();
        push_line(LW, 12'h111, 1'b0);
        push_line(LW, 12'hA5A, 1'b0);
        chk("s2_ready_low", 32'(in_ready), 32'd0);
        repeat (5) step();
        chk("s2_ready_held", 32'(in_ready), 32'd0);
        line_pulse();
        chk("s2_ready_first_ls", 32'(in_ready), 32'd0);
        step();
        chk("s2_ready_no_free", 32'(in_ready), 32'd0);
        read_line(8, LW, 12'h111);
        line_pulse();
        chk("s2_ready_freeing", 32'(in_ready), 32'd0);
        step();
        chk("s2_ready_refill", 32'(in_ready), 32'd1);
        read_line(8, LW, 12'hA5A);
        chk("s2_underflow", 32'(underflow), 32'd0);

        // short line closed by in_last, tail is black
        do_reset();
        push_line(100, 12'h3C3, 1'b1);
        line_pulse();
        read_line(LW, 100, 12'h3C3);
        chk("s3_underflow", 32'(underflow), 32'd0);

        // bank closes in the same cycle as line_start
        do_reset();
        push_line(9, 12'h0F0, 1'b0);
        in_valid = 1'b1; in_data = 12'(9) ^ 12'h0F0; in_last = 1'b1; line_start = 1'b1;
        chk("s5_ready_before", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0; line_start = 1'b0;
        chk("s5_underflow", 32'(underflow), 32'd1);
        read_line(4, 0, 12'h000);
        line_pulse();
        chk("s5_underflow_sticky", 32'(underflow), 32'd1);
        read_line(12, 10, 12'h0F0);

        // reset mid-fill and mid-readout
        do_reset();
        step();
        line_pulse();
        chk("s6_underflow_set", 32'(underflow), 32'd1);
        push_line(50, 12'h555, 1'b1);
        push_line(20, 12'h00F, 1'b0);
        line_pulse();
        read_line(5, 50, 12'h555);
        pix_en = 1'b1; rst = 1'b1;
        step();
        chk("s6_rst_rgb", 32'({R, G, B}), 32'h0);
        chk("s6_rst_uf", 32'(underflow), 32'd0);
        chk("s6_rst_ready", 32'(in_ready), 32'd0);
        pix_en = 1'b0; rst = 1'b0;
        push_line(60, 12'h246, 1'b1);
        line_pulse();
        read_line(64, 60, 12'h246);
        chk("s6_underflow_after", 32'(underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
